// File: rtl/hash_se_pkg.sv
// Shared types and helpers for the hash search-engine client: FSM encoding,
// MAC hash fold, broadcast constant and default timing parameters.
package hash_se_pkg;

    localparam int unsigned MAC_W  = 48;
    localparam int unsigned PMAP_W = 16;
    localparam int unsigned PORT_W = 4;
    localparam int unsigned HASH_W = 10;
    localparam int unsigned AGE_W  = 24;
    localparam int unsigned TO_W   = 8;

    localparam logic [MAC_W-1:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;
    localparam logic [AGE_W-1:0] AGE_PERIOD_DEF = 24'd12_500_000;
    localparam logic [TO_W-1:0]  SE_TIMEOUT_DEF = 8'd64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEARN  = 2'd1,
        LOOKUP = 2'd2,
        DONE   = 2'd3
    } state_t;

    // XOR-fold of the 48-bit MAC into a 10-bit bucket index
    function automatic logic [HASH_W-1:0] hash_fold(input logic [MAC_W-1:0] mac);
        return mac[9:0] ^ mac[19:10] ^ mac[29:20] ^ mac[39:30] ^ {2'b00, mac[47:40]};
    endfunction

    function automatic logic [PMAP_W-1:0] port_onehot(input logic [PORT_W-1:0] port);
        return PMAP_W'(1) << port;
    endfunction

endpackage

// File: rtl/hash_age_timer.sv
// Free-running aging sweep timer with a single-entry req/ack holder;
// a wrap while a request is still pending is dropped, not queued.
module hash_age_timer
    import hash_se_pkg::*;
#(
    parameter logic [AGE_W-1:0] AGE_PERIOD = AGE_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic aging_ack,
    output logic aging_req
);

    logic [AGE_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == AGE_PERIOD - AGE_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            aging_req <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + AGE_W'(1);
            if (aging_req && aging_ack) begin
                aging_req <= 1'b0;
            end else if (wrap) begin
                aging_req <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_se_client.sv
// Header client for the MAC hash search engine: learns the source MAC, looks
// up the destination MAC, and runs the aging timer. Optional response timeout
// is enabled by defining HASH_SE_TIMEOUT_EN.
module hash_se_client
    import hash_se_pkg::*;
#(
    parameter logic [AGE_W-1:0] AGE_PERIOD = AGE_PERIOD_DEF,
    parameter logic [TO_W-1:0]  SE_TIMEOUT = SE_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    output logic              in_ack,
    input  logic [MAC_W-1:0]  in_dmac,
    input  logic [MAC_W-1:0]  in_smac,
    input  logic [PORT_W-1:0] in_port,
    output logic              out_valid,
    output logic [PMAP_W-1:0] out_portmap,
    output logic              out_hit,
    output logic              se_source,
    output logic              se_req,
    output logic [MAC_W-1:0]  se_mac,
    output logic [PMAP_W-1:0] se_portmap,
    output logic [HASH_W-1:0] se_hash,
    input  logic              se_ack,
    input  logic              se_nak,
    input  logic [PMAP_W-1:0] se_result,
    output logic              aging_req,
    input  logic              aging_ack,
    output logic [15:0]       learn_drop
);

    state_t            state;
    logic [MAC_W-1:0]  dmac_q;
    logic [MAC_W-1:0]  smac_q;
    logic [PORT_W-1:0] port_q;
    logic [PMAP_W-1:0] port_oh;
    logic              resp_ack;
    logic              resp_nak;
    logic              resp_to;

    assign port_oh  = port_onehot(port_q);
    assign resp_ack = se_req && se_ack;
    assign resp_nak = se_req && !se_ack && se_nak;

`ifdef HASH_SE_TIMEOUT_EN
    // Counts cycles the current request has been outstanding
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= se_req ? to_cnt + TO_W'(1) : '0;
        end
    end

    assign resp_to = se_req && !se_ack && !se_nak && (to_cnt == SE_TIMEOUT - TO_W'(1));
`else
    assign resp_to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dmac_q      <= '0;
            smac_q      <= '0;
            port_q      <= '0;
            in_ack      <= 1'b0;
            out_valid   <= 1'b0;
            out_portmap <= '0;
            out_hit     <= 1'b0;
            se_source   <= 1'b0;
            se_req      <= 1'b0;
            se_mac      <= '0;
            se_portmap  <= '0;
            se_hash     <= '0;
            learn_drop  <= '0;
        end else begin
            in_ack    <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_req) begin
                        dmac_q <= in_dmac;
                        smac_q <= in_smac;
                        port_q <= in_port;
                        in_ack <= 1'b1;
                        // Multicast sources are never learned
                        state  <= in_smac[40] ? LOOKUP : LEARN;
                    end
                end
                LEARN: begin
                    if (!se_req) begin
                        se_req     <= 1'b1;
                        se_source  <= 1'b1;
                        se_mac     <= smac_q;
                        se_portmap <= port_oh;
                        se_hash    <= hash_fold(smac_q);
                    end else if (resp_ack) begin
                        se_req <= 1'b0;
                        state  <= LOOKUP;
                    end else if (resp_nak || resp_to) begin
                        se_req <= 1'b0;
                        if (learn_drop != 16'hFFFF) begin
                            learn_drop <= learn_drop + 16'd1;
                        end
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // se_req is always low on entry, so a new request never abuts the last
                    if (!se_req) begin
                        if (dmac_q == BCAST_MAC) begin
                            out_portmap <= ~port_oh;
                            out_hit     <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            se_req     <= 1'b1;
                            se_source  <= 1'b0;
                            se_mac     <= dmac_q;
                            se_portmap <= port_oh;
                            se_hash    <= hash_fold(dmac_q);
                        end
                    end else if (resp_ack) begin
                        se_req      <= 1'b0;
                        out_portmap <= se_result & ~port_oh;
                        out_hit     <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (resp_nak) begin
                        se_req      <= 1'b0;
                        out_portmap <= se_result;
                        out_hit     <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (resp_to) begin
                        se_req      <= 1'b0;
                        out_portmap <= ~port_oh;
                        out_hit     <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    hash_age_timer #(
        .AGE_PERIOD(AGE_PERIOD)
    ) u_age_timer (
        .clk      (clk),
        .rst      (rst),
        .aging_ack(aging_ack),
        .aging_req(aging_req)
    );

endmodule
